tick_period_meter: RTL and testbench



---
 rtl/tick_period_meter.sv | 153 +++++++++++++++
 tb/tb_tick_period_meter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_period_meter.sv
// Measures the clk_in-cycle interval between tick_in strobes, flags lock and loss of ticks.
// Optional running min/max period tracking is enabled by defining TICK_MINMAX_EN.
module tick_period_meter #(
    parameter int CNT_W      = 21,
    parameter int EXP_PERIOD = 10000,
    parameter int TOL        = 0,
    parameter int LOCK_N     = 4,
    parameter int TIMEOUT    = 2**21-1
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             tick_in,
`ifdef TICK_MINMAX_EN
    input  logic             minmax_clr,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max,
`endif
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             in_tol,
    output logic             locked,
    output logic             timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_MEAS = 2'd2;

    localparam logic [CNT_W-1:0]        TO_V   = CNT_W'(TIMEOUT);
    localparam logic signed [CNT_W:0]   EXP_S  = (CNT_W+1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]          TOL_V  = (CNT_W+1)'(TOL);
    localparam logic [3:0]              LOCK_V = 4'(LOCK_N);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pv_q, pv_d;
    logic             intol_q, intol_d;
    logic [3:0]       lock_q, lock_d;
    logic             to_q, to_d;

    logic                    tick_ev, measure, gap_sat, tol_ok;
    logic signed [CNT_W:0]   diff;
    logic [CNT_W:0]          mag;

    assign tick_ev = enable & tick_in;
    assign measure = tick_ev & (state_q == S_MEAS);
    assign gap_sat = (gap_q == TO_V);

    // Signed difference one bit wider than the counter so the magnitude never wraps.
    assign diff   = $signed({1'b0, gap_q}) - EXP_S;
    assign mag    = (diff < 0) ? -diff : diff;
    assign tol_ok = (mag <= TOL_V);

    always_comb begin
        state_d  = state_q;
        gap_d    = tick_ev ? CNT_W'(1) : (gap_sat ? gap_q : gap_q + CNT_W'(1));
        period_d = period_q;
        pv_d     = 1'b0;
        intol_d  = intol_q;
        lock_d   = lock_q;
        to_d     = to_q;
        if (!enable) begin
            state_d = S_IDLE;
            intol_d = 1'b0;
            lock_d  = 4'd0;
            to_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_ARM;
                S_ARM: begin
                    if (tick_in) begin
                        state_d = S_MEAS;
                        to_d    = 1'b0;
                    end
                end
                S_MEAS: begin
                    // A tick on the saturation cycle wins over the timeout.
                    if (tick_in) begin
                        period_d = gap_q;
                        pv_d     = 1'b1;
                        intol_d  = tol_ok;
                        lock_d   = !tol_ok ? 4'd0 :
                                   (lock_q == LOCK_V) ? lock_q : lock_q + 4'd1;
                    end else if (gap_sat) begin
                        to_d    = 1'b1;
                        lock_d  = 4'd0;
                        state_d = S_ARM;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q  <= S_IDLE;
            gap_q    <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            intol_q  <= 1'b0;
            lock_q   <= 4'd0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            intol_q  <= intol_d;
            lock_q   <= lock_d;
            to_q     <= to_d;
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign in_tol       = intol_q;
    assign locked       = (lock_q == LOCK_V);
    assign timeout      = to_q;

`ifdef TICK_MINMAX_EN
    logic [CNT_W-1:0] min_q, min_d, max_q, max_d;

    // A clear coinciding with a measurement seeds both extremes with that period.
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (minmax_clr) begin
            min_d = measure ? gap_q : '1;
            max_d = measure ? gap_q : '0;
        end else if (measure) begin
            if (gap_q < min_q) min_d = gap_q;
            if (gap_q > max_q) max_d = gap_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign period_min = min_q;
    assign period_max = max_q;
`endif

endmodule

// File: tb/tb_tick_period_meter.sv
// Randomized + directed bench for tick_period_meter with a cycle-level behavioural model.
// Min/max outputs are exercised when TICK_MINMAX_EN is defined.
module tb_tick_period_meter;

    localparam int CNT_W = 21;
    localparam int EXP   = 1000;
    localparam int TOL   = 2;
    localparam int LOCKN = 4;
    localparam int TO    = 2000;
    localparam logic [CNT_W-1:0] ONES = '1;

    logic clk_in = 1'b0;
    logic reset = 1'b1, enable = 1'b0, tick_in = 1'b0, minmax_clr = 1'b0;
    logic [CNT_W-1:0] period;
    logic period_valid, in_tol, locked, timeout;
`ifdef TICK_MINMAX_EN
    logic [CNT_W-1:0] period_min, period_max;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    tick_period_meter #(
        .CNT_W(CNT_W), .EXP_PERIOD(EXP), .TOL(TOL), .LOCK_N(LOCKN), .TIMEOUT(TO)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .enable(enable),
        .tick_in(tick_in),
`ifdef TICK_MINMAX_EN
        .minmax_clr(minmax_clr),
        .period_min(period_min),
        .period_max(period_max),
`endif
        .period(period),
        .period_valid(period_valid),
        .in_tol(in_tol),
        .locked(locked),
        .timeout(timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: tracks the cycle of the reference tick and derives periods by subtraction.
    int   cyc = 0;
    bit   m_active = 0, m_have_ref = 0;
    int   m_ref = 0;
    int   m_period = 0, m_streak = 0;
    bit   m_pv = 0, m_intol = 0, m_to = 0;
    logic [CNT_W-1:0] m_min = '1, m_max = '0;

    initial begin
        forever begin
            logic rs, en, tk, cl;
            bit meas;
            int el, k, d;
            @(posedge clk_in);
            rs = reset; en = enable; tk = tick_in; cl = minmax_clr;
            cyc++;
            meas = 0;
            k = 0;
            if (rs) begin
                m_active = 0; m_have_ref = 0; m_period = 0; m_pv = 0;
                m_intol = 0; m_streak = 0; m_to = 0; m_min = '1; m_max = '0;
            end else begin
                m_pv = 0;
                if (!en) begin
                    m_active = 0; m_have_ref = 0; m_intol = 0; m_streak = 0; m_to = 0;
                end else begin
                    if (m_have_ref) begin
                        el = cyc - m_ref;
                        k  = (el > TO) ? TO : el;
                        if (tk) begin
                            meas = 1; m_period = k; m_pv = 1; m_ref = cyc;
                            d = k - EXP;
                            if (d < 0) d = -d;
                            m_intol  = (d <= TOL);
                            m_streak = m_intol ? ((m_streak + 1 > LOCKN) ? LOCKN : m_streak + 1) : 0;
                        end else if (el >= TO) begin
                            m_to = 1; m_streak = 0; m_have_ref = 0;
                        end
                    end else if (m_active && tk) begin
                        m_have_ref = 1; m_ref = cyc; m_to = 0;
                    end
                    m_active = 1;
                end
                if (cl) begin
                    m_min = meas ? CNT_W'(k) : '1;
                    m_max = meas ? CNT_W'(k) : '0;
                end else if (meas) begin
                    if (CNT_W'(k) < m_min) m_min = CNT_W'(k);
                    if (CNT_W'(k) > m_max) m_max = CNT_W'(k);
                end
            end
            @(negedge clk_in);
            chk("period", 32'(period), 32'(m_period));
            chk("period_valid", 32'(period_valid), 32'(m_pv));
            chk("in_tol", 32'(in_tol), 32'(m_intol));
            chk("locked", 32'(locked), 32'(m_streak == LOCKN));
            chk("timeout", 32'(timeout), 32'(m_to));
`ifdef TICK_MINMAX_EN
            chk("period_min", 32'(period_min), 32'(m_min));
            chk("period_max", 32'(period_max), 32'(m_max));
`endif
        end
    end

    task automatic drive(input logic en, input logic tk, input logic cl);
        @(negedge clk_in);
        enable = en; tick_in = tk; minmax_clr = cl;
    endtask

    // Tick exactly k cycles after the previous tick.
    task automatic gap_then_tick(input int k, input logic cl);
        repeat (k - 1) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, cl);
    endtask

    task automatic settle;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        int per_b[7]   = '{1002, 998, 1003, 1001, 999, 1000, 1002};
        bit tol_b[7]   = '{1, 1, 0, 1, 1, 1, 1};
        bit lck_b[7]   = '{1, 1, 0, 0, 0, 0, 1};
        int mm_p[3]    = '{998, 1002, 1000};

        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_period", 32'(period), 0);
        chk("rst_valid", 32'(period_valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_timeout", 32'(timeout), 0);
        @(negedge clk_in) reset = 1'b0;

        // Lock on a steady stream; first tick only arms.
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        settle;
        chk("arm_no_valid", 32'(period_valid), 0);
        for (int i = 1; i <= 4; i++) begin
            gap_then_tick(EXP, 1'b0);
            settle;
            chk("lock_period", 32'(period), 32'(EXP));
            chk("lock_in_tol", 32'(in_tol), 1);
            chk("lock_locked", 32'(locked), 32'(i == 4));
        end

        // Tolerance boundaries and relock.
        for (int i = 0; i < 7; i++) begin
            gap_then_tick(per_b[i], 1'b0);
            settle;
            chk("tol_in_tol", 32'(in_tol), 32'(tol_b[i]));
            chk("tol_locked", 32'(locked), 32'(lck_b[i]));
        end

        // Timeout exactly TO cycles after the last tick.
        repeat (TO - 1) drive(1'b1, 1'b0, 1'b0);
        settle;
        chk("to_early", 32'(timeout), 0);
        drive(1'b1, 1'b0, 1'b0);
        settle;
        chk("to_fire", 32'(timeout), 1);
        chk("to_unlock", 32'(locked), 0);
        drive(1'b1, 1'b1, 1'b0);
        settle;
        chk("to_clear", 32'(timeout), 0);
        chk("to_rearm_valid", 32'(period_valid), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            settle;
            chk("b2b_valid", 32'(period_valid), 1);
            chk("b2b_period", 32'(period), 1);
        end

        // Drop enable while locked, with a coincident tick.
        for (int i = 0; i < 4; i++) gap_then_tick(EXP, 1'b0);
        settle;
        chk("pre_drop_locked", 32'(locked), 1);
        repeat (10) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        settle;
        chk("drop_locked", 32'(locked), 0);
        chk("drop_in_tol", 32'(in_tol), 0);
        chk("drop_valid", 32'(period_valid), 0);
        chk("drop_period", 32'(period), 32'(EXP));
        repeat (5) drive(1'b0, 1'b0, 1'b0);
        repeat (2) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        settle;
        chk("rearm_valid", 32'(period_valid), 0);
        gap_then_tick(EXP, 1'b0);
        settle;
        chk("rearm_period", 32'(period), 32'(EXP));

        // Min/max: clear coincides with the first measurement.
        for (int i = 0; i < 3; i++) gap_then_tick(mm_p[i], i == 0);
        settle;
`ifdef TICK_MINMAX_EN
        chk("mm_min", 32'(period_min), 998);
        chk("mm_max", 32'(period_max), 1002);
`endif
        drive(1'b1, 1'b0, 1'b1);
        settle;
`ifdef TICK_MINMAX_EN
        chk("mm_clr_min", 32'(period_min), 32'(ONES));
        chk("mm_clr_max", 32'(period_max), 0);
`endif

        // Tick landing on the saturation cycle is measured as TO.
        gap_then_tick(TO - 1, 1'b0);
        settle;
        chk("sat_period", 32'(period), 32'(TO));
        chk("sat_in_tol", 32'(in_tol), 0);
        chk("sat_timeout", 32'(timeout), 0);

        // Reset mid-measurement: next tick only arms.
        repeat (300) drive(1'b1, 1'b0, 1'b0);
        @(negedge clk_in) begin reset = 1'b1; tick_in = 1'b0; end
        @(negedge clk_in) reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        settle;
        chk("rst_mid_valid", 32'(period_valid), 0);
        gap_then_tick(EXP, 1'b0);
        settle;
        chk("rst_mid_period", 32'(period), 32'(EXP));

        // Random mix of periods, enable drops and clears.
        for (int i = 0; i < 25; i++) begin
            int r, k;
            r = int'($urandom_range(0, 99));
            if (r < 10) begin
                repeat ($urandom_range(1, 3)) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 50)      k = EXP - 2 + int'($urandom_range(0, 4));
                else if (r < 70) k = int'($urandom_range(1, 4));
                else if (r < 90) k = int'($urandom_range(990, 1010));
                else             k = int'($urandom_range(1900, 2100));
                gap_then_tick(k, $urandom_range(0, 9) == 0);
            end
        end

        repeat (5) drive(1'b1, 1'b0, 1'b0);
        settle;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
